// File: rtl/dmem_store_buffer.sv
// Data-memory responder for the M-stage port: a word RAM fronted by a FIFO store buffer.
// Stores retire into the buffer, drain to RAM on idle cycles, and loads forward from the youngest match.
module dmem_store_buffer #(
   parameter int DEPTH     = 4,
   parameter int ADDR_BITS = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwriteM,
   input  logic                     rdenM,
   input  logic [31:0]              aluoutM,
   input  logic [31:0]              writedataM,
   output logic [31:0]              readdataM,
   output logic                     stallM,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   typedef struct packed {
      logic [ADDR_BITS-1:0] idx;
      logic [31:0]          data;
   } entry_t;

   entry_t               sb_q  [DEPTH];
   logic [31:0]          ram_q [2**ADDR_BITS];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 full, enq, drain;
   logic [ADDR_BITS-1:0] word_idx;
   logic [PW-1:0]        slot;

   // Only the word-index bits of the byte address select storage.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{aluoutM[31:ADDR_BITS+2], aluoutM[1:0]};
   assign word_idx         = aluoutM[ADDR_BITS+1:2];
   assign sb_count         = count_q;

   // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      stallM  = memwriteM && full;
      enq     = !reset && memwriteM && !full;
      drain   = !reset && !memwriteM && !rdenM && (count_q != '0);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) begin
         tail_d  = tail_q + PW'(1);
         count_d = count_q + CNT_W'(1);
      end
      if (drain) begin
         head_d  = head_q + PW'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      readdataM = ram_q[word_idx];
      slot      = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head_q + PW'(i);
         if ((CNT_W'(i) < count_q) && (sb_q[slot].idx == word_idx)) begin
            readdataM = sb_q[slot].data;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: buffer slots and RAM carry no reset; slot validity comes from count_q and RAM must survive reset.
   always_ff @(posedge clk) begin
      if (enq) begin
         sb_q[tail_q] <= '{idx: word_idx, data: writedataM};
      end
      if (drain) begin
         ram_q[sb_q[head_q].idx] <= sb_q[head_q].data;
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: a queue-plus-array model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_dmem_store_buffer;

   localparam int DEPTH = 4;
   localparam int AB    = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwriteM = 1'b0;
   logic        rdenM = 1'b0;
   logic [31:0] aluoutM = '0;
   logic [31:0] writedataM = '0;
   logic [31:0] readdataM;
   logic        stallM;
   logic [2:0]  sb_count;

   int checks   = 0;
   int failures = 0;

   dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwriteM  (memwriteM),
      .rdenM      (rdenM),
      .aluoutM    (aluoutM),
      .writedataM (writedataM),
      .readdataM  (readdataM),
      .stallM     (stallM),
      .sb_count   (sb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AB-1:0] idx;
      logic [31:0]   data;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_ram   [2**AB];
   bit          m_known [2**AB];
   bit          model_live = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns {known, data}: youngest buffered store to the word, else RAM if ever written.
   function automatic logic [32:0] model_read(input logic [31:0] a);
      logic [AB-1:0] idx = a[AB+1:2];
      for (int i = m_q.size() - 1; i >= 0; i--) begin
         if (m_q[i].idx == idx) return {1'b1, m_q[i].data};
      end
      if (m_known[idx]) return {1'b1, m_ram[idx]};
      return '0;
   endfunction

   // Advance one clock, applying the buffer rules to the model at the edge.
   task automatic step();
      ent_t e;
      @(posedge clk);
      if (reset) begin
         m_q.delete();
         model_live = 1'b1;
      end else if (memwriteM) begin
         if (m_q.size() < DEPTH) m_q.push_back('{aluoutM[AB+1:2], writedataM});
      end else if (!rdenM && m_q.size() > 0) begin
         e = m_q.pop_front();
         m_ram[e.idx]   = e.data;
         m_known[e.idx] = 1'b1;
      end
      #1;
   endtask

   task automatic set(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      memwriteM  = w;
      rdenM      = r;
      aluoutM    = a;
      writedataM = d;
   endtask

   // Per-cycle comparison against the model, mid-cycle with inputs stable.
   initial begin
      logic [32:0] rd;
      forever begin
         @(negedge clk);
         if (model_live && !reset) begin
            check("cyc_count", 32'(sb_count), 32'(m_q.size()));
            check("cyc_stall", 32'(stallM), 32'(memwriteM && (m_q.size() == DEPTH)));
            rd = model_read(aluoutM);
            if (rd[32]) check("cyc_rdata", readdataM, rd[31:0]);
         end
      end
   end

   initial begin
      set(0, 0, 0, 0);
      step();
      step();
      reset = 1'b0;

      // Preload word 0, then reset must leave RAM intact.
      set(1, 0, 32'h0, 32'h1111_1111); step();
      set(0, 0, 32'h0, 0);             step();
      reset = 1'b1;                    step();
      reset = 1'b0;
      set(0, 1, 32'h0, 0); #1;
      check("t1_count", 32'(sb_count), 0);
      check("t1_stall", 32'(stallM), 0);
      check("t1_rdata", readdataM, 32'h1111_1111);

      // Forward from buffer, then read the same word from RAM after draining.
      set(1, 0, 32'h100, 32'hDEAD_BEEF); step();
      set(0, 1, 32'h100, 0); #1;
      check("t2_fwd", readdataM, 32'hDEAD_BEEF);
      check("t2_count1", 32'(sb_count), 1);
      step();
      set(0, 0, 32'h100, 0); step();
      set(0, 1, 32'h100, 0); #1;
      check("t2_count0", 32'(sb_count), 0);
      check("t2_ram", readdataM, 32'hDEAD_BEEF);

      // Duplicate stores resolve to the youngest.
      set(1, 0, 32'h40, 32'd1); step();
      set(1, 0, 32'h40, 32'd2); step();
      set(0, 1, 32'h40, 0); #1;
      check("t3_youngest", readdataM, 32'd2);
      check("t3_count2", 32'(sb_count), 2);
      set(0, 0, 32'h40, 0); step(); step();
      set(0, 1, 32'h40, 0); #1;
      check("t3_ram", readdataM, 32'd2);
      check("t3_count0", 32'(sb_count), 0);

      // Fill, stall on the fifth store, free one slot, re-present.
      for (int i = 0; i < 4; i++) begin
         set(1, 0, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i)); step();
      end
      set(1, 0, 32'h90, 32'hA4); #1;
      check("t4_stall", 32'(stallM), 1);
      check("t4_full", 32'(sb_count), 4);
      step();
      check("t4_held", 32'(sb_count), 4);
      set(0, 0, 32'h90, 0); step();
      set(1, 0, 32'h90, 32'hA4); #1;
      check("t4_count3", 32'(sb_count), 3);
      check("t4_nostall", 32'(stallM), 0);
      step();
      set(0, 1, 32'h90, 0); #1;
      check("t4_count4", 32'(sb_count), 4);
      check("t4_fwd5", readdataM, 32'hA4);
      set(0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) step();

      // Reset discards pending stores; RAM keeps the older values.
      for (int i = 0; i < 3; i++) begin
         set(1, 0, 32'h80 + 32'(4 * i), 32'hB0 + 32'(i)); step();
      end
      set(0, 0, 32'h84, 0);
      reset = 1'b1; step();
      reset = 1'b0;
      set(0, 1, 32'h84, 0); #1;
      check("t5_count", 32'(sb_count), 0);
      check("t5_rd84", readdataM, 32'hA1);
      aluoutM = 32'h88; #1;
      check("t5_rd88", readdataM, 32'hA2);

      // Loads hold off draining; idle cycles then drain one per cycle.
      set(1, 0, 32'hC0, 32'hC0); step();
      set(1, 0, 32'hC4, 32'hC4); step();
      set(0, 1, 32'hC0, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t6_hold", 32'(sb_count), 2);
      end
      set(0, 0, 32'hC0, 0); step();
      check("t6_drain1", 32'(sb_count), 1);
      step();
      check("t6_drain0", 32'(sb_count), 0);

      // Pointer wrap-around over 3*DEPTH store/idle pairs.
      for (int i = 0; i < 3 * DEPTH; i++) begin
         set(1, 0, 32'h1A0 + 32'(4 * i), 32'h5000 + 32'(i)); step();
         set(0, 0, 32'h0, 0); step();
      end
      for (int i = 0; i < 3 * DEPTH; i += 5) begin
         set(0, 1, 32'h1A0 + 32'(4 * i), 0); #1;
         check("t6_wrap_ram", readdataM, 32'h5000 + 32'(i));
      end
      check("t6_wrap_count", 32'(sb_count), 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
